// File: rtl/light_pen_capture.sv
// light_pen_capture: light-pen front-end producing one write strobe and the captured cell per pen touch
module light_pen_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int ALIGN_DELAY    = 3,
  parameter int FILTER_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pen_in,
  input  logic [7:0] scan_row,
  input  logic [7:0] scan_col,
  output logic       we,
  output logic [7:0] hit_row,
  output logic [7:0] hit_col,
  output logic       hit_valid,
  output logic       pen_active,
  output logic       err_onehot
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, QUAL, FIRE, HOLD} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [15:0] pos_q [ALIGN_DELAY];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic rel_q, rel_d;
  logic [7:0] hit_row_q, hit_col_q;
  logic hit_valid_q;
  logic pen_sync, qual, pos_ok, same, load;
  logic [15:0] pos_dly;
  assign pen_sync = sync_q[SYNC_STAGES-1];
  assign pos_dly = pos_q[ALIGN_DELAY-1];
  // qual stays true once saturated so a held pen re-qualifies after holdoff and hits the same-cell check
  assign qual = pen_sync && (cnt_q >= CW'(FILTER_CYCLES - 1));
  assign cnt_d = !pen_sync ? '0 : (cnt_q == CW'(FILTER_CYCLES)) ? cnt_q : cnt_q + CW'(1);
  assign pos_ok = (pos_dly[15:8] != 8'd0) && ((pos_dly[15:8] & (pos_dly[15:8] - 8'd1)) == 8'd0) &&
                  (pos_dly[7:0] != 8'd0) && ((pos_dly[7:0] & (pos_dly[7:0] - 8'd1)) == 8'd0);
  assign same = hit_valid_q && !rel_q && (pos_dly == {hit_row_q, hit_col_q});
  assign load = (state_d == FIRE);
  assign hold_d = (state_q == HOLD) ? hold_q + HW'(1) : '0;
  assign rel_d = !pen_sync || (rel_q && !load);
  assign hit_row = hit_row_q;
  assign hit_col = hit_col_q;
  assign hit_valid = hit_valid_q;
  assign pen_active = (cnt_q == CW'(FILTER_CYCLES));
  // free-running synchroniser and scan-position delay line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      for (int i = 0; i < ALIGN_DELAY; i++) pos_q[i] <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pen_in};
      pos_q[0] <= {scan_row, scan_col};
      for (int i = 1; i < ALIGN_DELAY; i++) pos_q[i] <= pos_q[i-1];
    end
  // filter, holdoff, release tracking and captured hit; the hit is loaded on the edge into FIRE so it accompanies we
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      hold_q <= '0;
      rel_q <= 1'b0;
      hit_row_q <= '0;
      hit_col_q <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      rel_q <= rel_d;
      if (load) {hit_row_q, hit_col_q, hit_valid_q} <= {pos_dly, 1'b1};
    end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic; en low always returns to IDLE
  always_comb begin
    state_d = !en ? IDLE :
              (state_q == IDLE) ? (pen_sync ? QUAL : IDLE) :
              (state_q == QUAL) ? (!pen_sync ? IDLE : !qual ? QUAL : (pos_ok && !same) ? FIRE : HOLD) :
              (state_q == FIRE) ? HOLD :
              (hold_q == HW'(HOLDOFF_CYCLES - 1)) ? IDLE : HOLD;
  end
  // strobe outputs
  always_comb begin
    we = (state_q == FIRE) && en;
    err_onehot = (state_q == QUAL) && en && qual && !pos_ok;
  end
endmodule

// File: tb/tb_light_pen_capture.sv
// tb_light_pen_capture: scoreboard bench for the light-pen capture front-end
module tb_light_pen_capture;
  logic clk = 0, rst = 1, en = 1, pen_in = 0;
  logic [7:0] scan_row = 0, scan_col = 0;
  logic we, hit_valid, pen_active, err_onehot;
  logic [7:0] hit_row, hit_col;
  typedef struct {int cyc; logic [7:0] row; logic [7:0] col;} exp_t;
  exp_t sb[$];
  int cyc = 0, n_chk = 0, n_err = 0, err_cnt = 0, err_cyc = -1, t, e0;
  logic prev_we = 0;
  light_pen_capture dut (
    .clk(clk), .rst(rst), .en(en), .pen_in(pen_in), .scan_row(scan_row), .scan_col(scan_col),
    .we(we), .hit_row(hit_row), .hit_col(hit_col), .hit_valid(hit_valid),
    .pen_active(pen_active), .err_onehot(err_onehot)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // monitor: every strobe is matched against the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && we) begin
      chk("we_not_back_to_back", prev_we, 0);
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL we_unexpected: got we=1 at cycle %0d required no strobe", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc >= 0) chk("we_cycle", cyc, e.cyc);
        chk("hit_pos", {hit_row, hit_col}, {e.row, e.col});
        chk("hit_valid_at_we", hit_valid, 1);
      end
    end
    if (!rst && err_onehot) begin
      err_cnt++;
      if (err_cyc < 0) err_cyc = cyc;
    end
    prev_we = we;
  end
  initial begin
    pen_in = 1;
    scan_row = 8'h04;
    scan_col = 8'h10;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {we, hit_valid, pen_active, err_onehot, hit_row, hit_col}, 0);
    end
    @(posedge clk);
    #1;
    rst = 0;
    t = cyc;
    sb.push_back('{t + 6, 8'h04, 8'h10});
    tick(5);
    @(negedge clk);
    chk("pen_active_before_qual", pen_active, 0);
    tick(1);
    @(negedge clk);
    chk("pen_active_after_qual", pen_active, 1);
    tick(34);
    chk("single_touch_done", sb.size(), 0);
    chk("hit_row_single", hit_row, 8'h04);
    chk("hit_col_single", hit_col, 8'h10);
    chk("hit_valid_single", hit_valid, 1);
    pen_in = 0;
    scan_row = 8'h02;
    scan_col = 8'h80;
    tick(20);
    chk("pen_active_released", pen_active, 0);
    pen_in = 1;
    t = cyc;
    sb.push_back('{t + 6, 8'h02, 8'h80});
    tick(100);
    chk("held_one_we", sb.size(), 0);
    pen_in = 0;
    sb.push_back('{-1, 8'h02, 8'h80});
    tick(5);
    pen_in = 1;
    tick(40);
    chk("retouch_we", sb.size(), 0);
    pen_in = 0;
    tick(30);
    scan_row = 8'h08;
    t = cyc;
    sb.push_back('{t + 6, 8'h08, 8'h20});
    for (int i = 0; i < 40; i++) begin
      scan_col = 8'h01 << ((i + 3) % 8);
      pen_in = (i < 10);
      tick(1);
    end
    tick(10);
    chk("align_done", sb.size(), 0);
    chk("align_hit_col", hit_col, 8'h20);
    chk("align_hit_row", hit_row, 8'h08);
    scan_col = 8'h01;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k <= r % 3; k++) begin
        pen_in = 1;
        tick(1);
        @(negedge clk);
        chk("glitch_pen_active", pen_active, 0);
      end
      pen_in = 0;
      tick(2);
    end
    tick(10);
    chk("glitch_pen_active_end", pen_active, 0);
    chk("glitch_hit_col", hit_col, 8'h20);
    scan_row = 8'h00;
    e0 = err_cnt;
    pen_in = 1;
    t = cyc;
    tick(15);
    pen_in = 0;
    tick(25);
    chk("err_pulse_count", err_cnt - e0, 1);
    chk("err_pulse_cycle", err_cyc, t + 5);
    chk("err_hit_unchanged", {hit_row, hit_col}, 16'h0820);
    en = 0;
    scan_row = 8'h40;
    scan_col = 8'h02;
    e0 = err_cnt;
    pen_in = 1;
    tick(30);
    chk("en_low_pen_active", pen_active, 1);
    chk("en_low_hit_unchanged", {hit_row, hit_col}, 16'h0820);
    chk("en_low_no_err", err_cnt - e0, 0);
    pen_in = 0;
    tick(10);
    en = 1;
    tick(10);
    chk("final_scoreboard_empty", sb.size(), 0);
    chk("final_hit_valid", hit_valid, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
